// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared encodings for the EX-stage iterative multiply/divide unit.
// The aluop bit positions, the FSM state encoding and the operation decode live here.
// Build option: define MULDIV_MUL_EN to enable the iterative multiplier (MULT/MULTU).
package ex_muldiv_pkg;

  // One-hot operation bus delivered by the ID/EX register.
  localparam int ALUOP_W     = 8;
  localparam int ALUOP_DIV   = 0;
  localparam int ALUOP_DIVU  = 1;
  localparam int ALUOP_MULT  = 2;
  localparam int ALUOP_MULTU = 3;

  typedef logic [ALUOP_W-1:0] aluop_onehotbus_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ZERO = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Decoded request: whether to start, which datapath, and whether operands are signed.
  typedef struct packed {
    logic start;
    logic is_mul;
    logic is_signed;
  } md_op_t;

  // Several bits set at once is illegal input; resolve it as DIV > DIVU > MULT > MULTU.
  // Multiply bits are ignored entirely when the multiplier is not built.
  function automatic md_op_t decode_op(input aluop_onehotbus_t op, input logic mul_en);
    md_op_t d;
    d = '0;
    if (op[ALUOP_DIV]) begin
      d.start     = 1'b1;
      d.is_signed = 1'b1;
    end else if (op[ALUOP_DIVU]) begin
      d.start     = 1'b1;
    end else if (mul_en && op[ALUOP_MULT]) begin
      d.start     = 1'b1;
      d.is_mul    = 1'b1;
      d.is_signed = 1'b1;
    end else if (mul_en && op[ALUOP_MULTU]) begin
      d.start     = 1'b1;
      d.is_mul    = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// ex_muldiv_step: one combinational iteration of the multiply/divide datapath.
// Divide: restoring radix-2 step on {hi,lo} = {remainder, dividend/quotient}.
// Multiply (only with MULDIV_MUL_EN): shift-add step on {hi,lo} = {accumulator, multiplier}.
module ex_muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic              is_mul_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic [DATA_W-1:0] opb_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  // One extra bit so the trial subtraction's sign is visible even when the
  // shifted partial remainder exceeds DATA_W bits.
  logic [DATA_W:0] partial;
  logic [DATA_W:0] diff;
`ifdef MULDIV_MUL_EN
  logic [DATA_W:0] sum;
`else
  logic unused_is_mul;
  assign unused_is_mul = is_mul_i;
`endif

  // Single iteration: divide step by default, replaced by the multiply step when selected.
  always_comb begin
    // NOTE: every signal written here gets a value before any condition, so no path can infer a latch.
    partial = {hi_i, lo_i[DATA_W-1]};
    diff    = partial - {1'b0, opb_i};
    // Negative trial result: restore the shifted remainder and shift in a 0 quotient bit.
    hi_o    = diff[DATA_W] ? partial[DATA_W-1:0] : diff[DATA_W-1:0];
    lo_o    = {lo_i[DATA_W-2:0], ~diff[DATA_W]};
`ifdef MULDIV_MUL_EN
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opb_i} : '0);
    if (is_mul_i) begin
      hi_o = sum[DATA_W:1];
      lo_o = {sum[0], lo_i[DATA_W-1:1]};
    end
`endif
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit in the EX stage.
// Holds the pipeline via stallreq_o while iterating, then issues a one-cycle HI/LO write.
// Build option: MULDIV_MUL_EN enables MULT/MULTU; without it those bits are ignored.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  aluop_onehotbus_t  ex_aluop,
  input  logic [DATA_W-1:0] ex_reg1,
  input  logic [DATA_W-1:0] ex_reg2,
  input  logic              annul_i,
  input  logic              ext_stall_i,
  output logic              stallreq_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              whilo_o
);

`ifdef MULDIV_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d;      // remainder / product accumulator
  logic [DATA_W-1:0] lo_q, lo_d;      // quotient (dividend) / multiplier
  logic [DATA_W-1:0] opb_q, opb_d;    // divisor / multiplicand magnitude
  logic              neg_lo_q, neg_lo_d;  // operand signs differ: negate quotient / product
  logic              neg_hi_q, neg_hi_d;  // dividend negative: negate remainder
`ifdef MULDIV_MUL_EN
  logic              is_mul_q, is_mul_d;
  logic [2*DATA_W-1:0] prod;
`endif
  logic              step_is_mul;

  md_op_t            dec;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_abs, b_abs;
  logic [DATA_W-1:0] step_hi, step_lo;

  // Bits of the shared aluop bus that belong to other EX units.
  logic unused_aluop_hi;
  assign unused_aluop_hi = ^ex_aluop[ALUOP_W-1:ALUOP_MULTU+1];

  // Decode the incoming request and form operand magnitudes for signed ops.
  always_comb begin
    dec   = decode_op(ex_aluop, MUL_EN);
    a_neg = dec.is_signed & ex_reg1[DATA_W-1];
    b_neg = dec.is_signed & ex_reg2[DATA_W-1];
    a_abs = a_neg ? -ex_reg1 : ex_reg1;
    b_abs = b_neg ? -ex_reg2 : ex_reg2;
  end

`ifdef MULDIV_MUL_EN
  assign step_is_mul = is_mul_q;
`else
  assign step_is_mul = 1'b0;
`endif

  ex_muldiv_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .is_mul_i (step_is_mul),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opb_i    (opb_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Next-state, datapath update and the stall/write handshakes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opb_d      = opb_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
`ifdef MULDIV_MUL_EN
    is_mul_d   = is_mul_q;
`endif
    stallreq_o = 1'b0;
    whilo_o    = 1'b0;

    if (annul_i) begin
      // Flush aborts everything, including a start presented in the same cycle.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Gating with rst keeps the combinational stall request low while reset is held.
          if (dec.start && rst) begin
            stallreq_o = 1'b1;
            cnt_d      = '0;
            hi_d       = '0;
            neg_lo_d   = a_neg ^ b_neg;
            neg_hi_d   = a_neg;
`ifdef MULDIV_MUL_EN
            is_mul_d   = dec.is_mul;
`endif
            if (!dec.is_mul && (ex_reg2 == '0)) begin
              state_d = ST_ZERO;
            end else begin
              state_d = ST_RUN;
              if (dec.is_mul) begin
                opb_d = a_abs;
                lo_d  = b_abs;
              end else begin
                opb_d = b_abs;
                lo_d  = a_abs;
              end
            end
          end
        end
        ST_ZERO: begin
          stallreq_o = 1'b1;
          hi_d       = '0;
          lo_d       = '0;
          neg_lo_d   = 1'b0;
          neg_hi_d   = 1'b0;
          state_d    = ST_DONE;
        end
        ST_RUN: begin
          stallreq_o = 1'b1;
          hi_d       = step_hi;
          lo_d       = step_lo;
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          // Later stages stalled: hold the result and retry the write next cycle.
          if (!ext_stall_i) begin
            whilo_o = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Result presentation with sign fixup; only meaningful in DONE, zero elsewhere.
  always_comb begin
    hi_o = '0;
    lo_o = '0;
`ifdef MULDIV_MUL_EN
    prod = neg_lo_q ? -{hi_q, lo_q} : {hi_q, lo_q};
`endif
    if (state_q == ST_DONE) begin
      hi_o = neg_hi_q ? -hi_q : hi_q;
      lo_o = neg_lo_q ? -lo_q : lo_q;
`ifdef MULDIV_MUL_EN
      if (is_mul_q) begin
        hi_o = prod[2*DATA_W-1:DATA_W];
        lo_o = prod[DATA_W-1:0];
      end
`endif
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: datapath registers are reset along with the FSM so no X can ever reach HI/LO.
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
`ifdef MULDIV_MUL_EN
      is_mul_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
`ifdef MULDIV_MUL_EN
      is_mul_q <= is_mul_d;
`endif
    end
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage of the five-stage pipeline. It consumes the decoded operation and operands that the ID/EX register delivers, and drives a stall request back toward that register while it works. On completion it produces a one-cycle HI/LO write. Division uses restoring radix-2 (one quotient bit per cycle); multiplication uses shift-add and is a compile-time option.

## Interface
- DATA_W, 32, operand/result width
- CNT_W, 6, iteration counter width (≥ log2(DATA_W)+1)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- ex_aluop  in  `aluop_onehotbus  one-hot operation from ID/EX; bits DIV, DIVU, MULT, MULTU used
- ex_reg1  in  DATA_W  dividend / multiplicand
- ex_reg2  in  DATA_W  divisor / multiplier
- annul_i  in  1  flush from pipeline control; aborts any operation
- ext_stall_i  in  1  stall from later stages (MEM/WB)
- stallreq_o  out  1  hold request to pipeline control (freezes PC, IF/ID, ID/EX)
- hi_o  out  DATA_W  remainder / product high word
- lo_o  out  DATA_W  quotient / product low word
- whilo_o  out  1  HI/LO write strobe

## Operation
- States: IDLE, ZERO, RUN, DONE.
- IDLE:
  - Start when a supported op bit is set and annul_i=0. Priority when multiple bits are set (illegal input): DIV > DIVU > MULT > MULTU.
  - stallreq_o is driven combinationally high in the start cycle, so ID/EX holds.
  - Divide with ex_reg2==0 → ZERO. Otherwise capture operands → RUN with count=0.
  - Signed ops (DIV/MULT) capture absolute values plus the two sign flags.
- RUN, one step per cycle:
  - Divide: shift {rem,quot} left, trial-subtract divisor, set quotient bit on non-negative result.
  - Multiply: add multiplicand when the multiplier LSB is 1, then shift right.
  - After step DATA_W−1 → DONE.
- ZERO: one cycle, forces hi=lo=0 → DONE.
- DONE:
  - Sign fixup. Quotient is negated when the signs differ (DIV). Remainder takes the dividend's sign. Product is negated when the signs differ (MULT).
  - hi_o/lo_o valid; stallreq_o=0.
  - whilo_o=1 only when ext_stall_i=0, and the state then moves to IDLE. While ext_stall_i=1, stay in DONE with outputs stable and whilo_o=0.
- annul_i=1 in any state → next state IDLE; stallreq_o=0 and whilo_o=0 in that cycle. annul_i wins over a simultaneous start.
- Unsigned arithmetic is modulo 2^DATA_W. A signed DIV of 0x80000000/−1 yields lo=0x80000000, hi=0.
- All outputs reset to 0 and the state resets to IDLE. Reset asserted mid-operation discards the operation.

## Timing
- Start cycle T (IDLE) → RUN T+1..T+DATA_W → DONE T+DATA_W+1. whilo_o is high at T+33 for DATA_W=32.
- stallreq_o is high T..T+DATA_W and low from DONE onward.
- Divide by zero: ZERO at T+1, DONE at T+2. stallreq_o is high for 2 cycles.
- The pipeline advances on the DONE cycle, so the following instruction is seen in IDLE at the next cycle. There is no back-to-back gap penalty beyond one IDLE cycle.
- whilo_o is a single-cycle pulse per completed operation.

## Configuration
- `MULDIV_MUL_EN` defined: MULT/MULTU start the iterative multiply (same latency as divide).
- `MULDIV_MUL_EN` undefined: the MULT/MULTU bits are ignored (no stall, no whilo). The multiply datapath and its sign logic are not built.

## Structure
- Shared defines.v holds:
  - aluop bit indices for DIV, DIVU, MULT, MULTU
  - state encodings
  - `MULDIV_MUL_EN
- Sub-module muldiv_step: combinational single iteration (restoring subtract-shift or add-shift, op-selected). Instantiated once inside ex_muldiv.

## Test plan
- DIVU 100/7 at T → stallreq_o high 33 cycles; at T+33 whilo_o=1, lo_o=14, hi_o=2.
- DIV −7/2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- DIV 5/0 → stallreq_o high 2 cycles; whilo_o at T+2 with hi_o=lo_o=0.
- annul_i pulse at T+10 of a DIVU → T+11 IDLE, stallreq_o=0, no whilo_o. rst low at T+5 of a second op → all outputs 0 immediately.
- ext_stall_i high for 3 cycles on entering DONE → hi_o/lo_o stable, whilo_o exactly once when ext_stall_i falls.
- MULT −2×3 with `MULDIV_MUL_EN` → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA after 33 cycles. Without the macro → stallreq_o and whilo_o stay 0.
